// File: rtl/dds_pkg.sv
// Shared definitions for the DDS configuration controller: FSM states,
// waveform codes and the frequency-index to phase-increment table.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_INIT_CFG = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESS    = 2'd2,
        ST_UPDATE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAWTOOTH = 2'd3
    } wave_e;

    // Octave-spaced phase increments, one per frequency index.
    localparam logic [31:0] PHASE_INC [8] = '{
        32'h0001_0C6F, 32'h0002_18DF, 32'h0004_31BE, 32'h0008_637C,
        32'h0010_C6F8, 32'h0021_8DEF, 32'h0043_1BDE, 32'h0086_37BD
    };

    function automatic logic [31:0] phase_inc_lookup(input logic [2:0] idx);
        return PHASE_INC[idx];
    endfunction

    function automatic wave_e next_wave(input wave_e w);
        case (w)
            WAVE_SINE:     return WAVE_SQUARE;
            WAVE_SQUARE:   return WAVE_TRIANGLE;
            WAVE_TRIANGLE: return WAVE_SAWTOOTH;
            WAVE_SAWTOOTH: return WAVE_SINE;
            default:       return WAVE_SINE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for a raw
// push-button; o_level only moves after DB_CNT consecutive differing cycles.
module btn_debounce #(
    parameter int DB_CNT = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level
);

    localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    logic          r_sync_0;
    logic          r_sync_1;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Synchronize the asynchronous button into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= i_btn;
            r_sync_1 <= r_sync_0;
        end
    end

    // Any cycle matching the current level restarts the stability count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync_1 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync_1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/dds_config_ctrl.sv
// Single-button DDS configuration controller: short press steps the frequency
// index, long press steps the waveform, each change is offered via valid/ready.
module dds_config_ctrl
    import dds_pkg::*;
#(
    parameter int DB_CNT   = 50000,
    parameter int LONG_CNT = 1000000
) (
    input  logic        Fg_CLK,
    input  logic        RESET,
    input  logic        IntBTN,
    input  logic        Ready,
    output logic        Cfg_Valid,
    output logic [1:0]  Wave_Sel,
    output logic [2:0]  Freq_Idx,
    output logic [31:0] Phase_Inc,
    output logic        Enable
);

    localparam int HW = $clog2(LONG_CNT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);

    logic          w_db_level;
    logic          w_rise;
    logic          w_fall;
    logic [2:0]    w_freq_next;

    state_e        r_state;
    logic          r_db_prev;
    logic [HW-1:0] r_hold;
    logic          r_cfg_valid;
    logic          r_enable;
    wave_e         r_wave;
    logic [2:0]    r_freq;
    logic [31:0]   r_phase;

    btn_debounce #(
        .DB_CNT (DB_CNT)
    ) u_debounce (
        .i_clk   (Fg_CLK),
        .i_rst   (RESET),
        .i_btn   (IntBTN),
        .o_level (w_db_level)
    );

    assign w_rise      = w_db_level & ~r_db_prev;
    assign w_fall      = ~w_db_level & r_db_prev;
    assign w_freq_next = r_freq + 3'd1;

    // Control FSM; Phase_Inc is loaded alongside Freq_Idx so both are valid
    // in the first Cfg_Valid cycle. Edges outside IDLE/PRESS are simply lost.
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            r_state     <= ST_INIT_CFG;
            r_db_prev   <= 1'b0;
            r_hold      <= '0;
            r_cfg_valid <= 1'b0;
            r_enable    <= 1'b0;
            r_wave      <= WAVE_SINE;
            r_freq      <= 3'd0;
            r_phase     <= phase_inc_lookup(3'd0);
        end else begin
            r_db_prev <= w_db_level;
            case (r_state)
                ST_INIT_CFG: begin
                    if (!r_cfg_valid) begin
                        r_cfg_valid <= 1'b1;
                    end else if (Ready) begin
                        r_cfg_valid <= 1'b0;
                        r_enable    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_rise) begin
                        r_hold  <= '0;
                        r_state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (w_fall) begin
                        if (r_hold >= HOLD_MAX) begin
                            r_wave <= next_wave(r_wave);
                        end else begin
                            r_freq  <= w_freq_next;
                            r_phase <= phase_inc_lookup(w_freq_next);
                        end
                        r_cfg_valid <= 1'b1;
                        r_enable    <= 1'b0;
                        r_state     <= ST_UPDATE;
                    end else if (r_hold < HOLD_MAX) begin
                        r_hold <= r_hold + {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                ST_UPDATE: begin
                    if (r_cfg_valid && Ready) begin
                        r_cfg_valid <= 1'b0;
                        r_enable    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_INIT_CFG;
                    r_cfg_valid <= 1'b0;
                    r_enable    <= 1'b0;
                end
            endcase
        end
    end

    assign Cfg_Valid = r_cfg_valid;
    assign Wave_Sel  = r_wave;
    assign Freq_Idx  = r_freq;
    assign Phase_Inc = r_phase;
    assign Enable    = r_enable;

endmodule

// File: tb/tb_dds_config_ctrl.sv
// Directed bench for dds_config_ctrl with short debounce/long-press thresholds.
module tb_dds_config_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic        rdy;
    logic        Cfg_Valid;
    logic [1:0]  Wave_Sel;
    logic [2:0]  Freq_Idx;
    logic [31:0] Phase_Inc;
    logic        Enable;

    logic [31:0] tbl [8] = '{
        32'h0001_0C6F, 32'h0002_18DF, 32'h0004_31BE, 32'h0008_637C,
        32'h0010_C6F8, 32'h0021_8DEF, 32'h0043_1BDE, 32'h0086_37BD
    };

    int n_cmp  = 0;
    int n_fail = 0;

    dds_config_ctrl #(.DB_CNT(4), .LONG_CNT(20)) dut (
        .Fg_CLK    (clk),
        .RESET     (rst),
        .IntBTN    (btn),
        .Ready     (rdy),
        .Cfg_Valid (Cfg_Valid),
        .Wave_Sel  (Wave_Sel),
        .Freq_Idx  (Freq_Idx),
        .Phase_Inc (Phase_Inc),
        .Enable    (Enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"},  {31'd0, Cfg_Valid}, 32'd0);
        chk({tag, " enable"}, {31'd0, Enable},    32'd0);
        chk({tag, " wave"},   {30'd0, Wave_Sel},  32'd0);
        chk({tag, " freq"},   {29'd0, Freq_Idx},  32'd0);
        chk({tag, " phase"},  Phase_Inc,          tbl[0]);
    endtask

    task automatic chk_offer(input string tag, input int w, input int f);
        chk({tag, " valid"},  {31'd0, Cfg_Valid}, 32'd1);
        chk({tag, " enable"}, {31'd0, Enable},    32'd0);
        chk({tag, " wave"},   {30'd0, Wave_Sel},  w);
        chk({tag, " freq"},   {29'd0, Freq_Idx},  f);
        chk({tag, " phase"},  Phase_Inc,          tbl[f]);
    endtask

    task automatic wait_cfg(input string tag);
        int k;
        k = 0;
        while (Cfg_Valid !== 1'b1 && k < 80) begin
            tick();
            k++;
        end
        chk({tag, " offer_seen"}, {31'd0, Cfg_Valid}, 32'd1);
    endtask

    task automatic press(input string tag, input int n);
        btn = 1'b1;
        repeat (n) tick();
        chk({tag, " enable_in_press"}, {31'd0, Enable}, 32'd1);
        btn = 1'b0;
    endtask

    // Press with Ready=1, expect a single-cycle offer, then back to enabled.
    task automatic full_press(input string tag, input int n, input int w, input int f);
        press(tag, n);
        wait_cfg(tag);
        chk_offer(tag, w, f);
        tick();
        chk({tag, " valid_drop"}, {31'd0, Cfg_Valid}, 32'd0);
        chk({tag, " enable_back"}, {31'd0, Enable}, 32'd1);
    endtask

    initial begin
        logic seen;
        logic stable;

        rst = 1'b1;
        btn = 1'b0;
        rdy = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");

        rdy = 1'b1;
        rst = 1'b0;
        tick();
        chk_offer("init_cfg", 0, 0);
        tick();
        chk({"init valid_drop"}, {31'd0, Cfg_Valid}, 32'd0);
        chk({"init enable"}, {31'd0, Enable}, 32'd1);

        repeat (5) tick();
        full_press("short1", 10, 0, 1);

        full_press("long1", 30, 1, 1);
        full_press("long2", 30, 2, 1);
        full_press("long3", 30, 3, 1);
        full_press("long_wrap", 30, 0, 1);

        for (int i = 2; i <= 7; i++) full_press($sformatf("short%0d", i), 10, 0, i);
        full_press("short_wrap", 10, 0, 0);

        // Bounce shorter than the debounce window must never register.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn = ~btn;
            tick();
            seen = seen | Cfg_Valid;
        end
        btn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | Cfg_Valid;
        end
        chk("bounce no_offer", {31'd0, seen}, 32'd0);
        chk("bounce wave", {30'd0, Wave_Sel}, 32'd0);
        chk("bounce freq", {29'd0, Freq_Idx}, 32'd0);

        // Backpressure: offer held, press during UPDATE dropped.
        rdy = 1'b0;
        press("bp", 10);
        wait_cfg("bp");
        chk_offer("bp", 0, 1);
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) btn = 1'b1;
            if (i == 6) btn = 1'b0;
            tick();
            if (!(Cfg_Valid === 1'b1 && Wave_Sel === 2'd0 && Freq_Idx === 3'd1 &&
                  Phase_Inc === tbl[1] && Enable === 1'b0)) stable = 1'b0;
        end
        chk("bp held_stable", {31'd0, stable}, 32'd1);
        rdy = 1'b1;
        tick();
        chk("bp valid_drop", {31'd0, Cfg_Valid}, 32'd0);
        chk("bp enable_back", {31'd0, Enable}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | Cfg_Valid;
        end
        chk("bp press_dropped", {31'd0, seen}, 32'd0);
        chk("bp freq_kept", {29'd0, Freq_Idx}, 32'd1);

        // Reset in the middle of a press.
        btn = 1'b1;
        repeat (12) tick();
        chk("midpress enable", {31'd0, Enable}, 32'd1);
        rst = 1'b1;
        btn = 1'b0;
        tick();
        chk_reset_vals("rst_midpress");
        rst = 1'b0;
        tick();
        chk_offer("rst_midpress init", 0, 0);
        tick();
        chk("rst_midpress enable", {31'd0, Enable}, 32'd1);

        // Reset while an update is pending.
        rdy = 1'b0;
        repeat (3) tick();
        press("midupd", 10);
        wait_cfg("midupd");
        chk_offer("midupd", 0, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_midupd");
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        chk_offer("rst_midupd init", 0, 0);
        tick();
        chk("rst_midupd valid_drop", {31'd0, Cfg_Valid}, 32'd0);
        chk("rst_midupd enable", {31'd0, Enable}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_config_ctrl.md
DDS_CONFIG_CTRL -- requirements
Module: dds_config_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 50000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter LONG_CNT, default 1000000, meaning debounced-held cycles at or above which a press is "long".
REQ-003 SHALL have port Fg_CLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port IntBTN  in  1  raw asynchronous push-button, active-high.
REQ-006 SHALL have port Ready  in  1  DDS datapath accepts configuration when high.
REQ-007 SHALL have port Cfg_Valid  out  1  configuration offered to datapath.
REQ-008 SHALL have port Wave_Sel  out  2  waveform code: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-009 SHALL have port Freq_Idx  out  3  frequency table index 0..7.
REQ-010 SHALL have port Phase_Inc  out  32  phase-accumulator increment for Freq_Idx.
REQ-011 SHALL have port Enable  out  1  output/sampling enable; high only when applied config is current.

Function
REQ-012 SHALL pass IntBTN through a 2-flop synchronizer before any other use.
REQ-013 SHALL change the debounced level only after the synchronized input differs from it for DB_CNT consecutive cycles; any bounce restarts the count.
REQ-014 SHALL implement FSM states INIT_CFG, IDLE, PRESS, UPDATE.
REQ-015 INIT_CFG: Cfg_Valid=1 with Wave_Sel=0, Freq_Idx=0; on Cfg_Valid&&Ready -> IDLE next cycle.
REQ-016 IDLE: on debounced rising edge -> PRESS, hold counter cleared to 0.
REQ-017 PRESS: hold counter increments each cycle, saturating at LONG_CNT (no wrap).
REQ-018 PRESS, debounced falling edge, counter >= LONG_CNT: Wave_Sel <= Wave_Sel+1 (3 wraps to 0), Freq_Idx unchanged, -> UPDATE.
REQ-019 PRESS, debounced falling edge, counter < LONG_CNT: Freq_Idx <= Freq_Idx+1 (7 wraps to 0), Wave_Sel unchanged, -> UPDATE.
REQ-020 UPDATE: Cfg_Valid=1; on Cfg_Valid&&Ready -> IDLE, Cfg_Valid=0 in the following cycle.
REQ-021 Phase_Inc SHALL be a registered table lookup of Freq_Idx, valid in the same cycle Cfg_Valid first asserts.
REQ-022 Wave_Sel, Freq_Idx, Phase_Inc SHALL remain stable while Cfg_Valid=1.
REQ-023 Button edges during INIT_CFG or UPDATE SHALL be ignored (not queued).
REQ-024 Ready high in the same cycle Cfg_Valid first asserts SHALL complete the transfer in that cycle (zero-wait).
REQ-025 Enable SHALL be 0 whenever Cfg_Valid=1 and from reset until the first transfer completes; 1 in IDLE and PRESS thereafter.
REQ-026 Ready while Cfg_Valid=0 SHALL have no effect.

Reset
REQ-027 RESET SHALL override all inputs, including mid-press or mid-UPDATE, returning to INIT_CFG.
REQ-028 In the cycle after RESET is sampled high: Cfg_Valid=0, Enable=0, Wave_Sel=0, Freq_Idx=0, Phase_Inc=table[0], debounced level=0, all counters 0.
REQ-029 First cycle after RESET deasserts SHALL enter INIT_CFG with Cfg_Valid=1.

Structure
REQ-030 Shared package dds_pkg SHALL hold the FSM state enum, waveform codes, and the 8-entry 32-bit PHASE_INC table.
REQ-031 Synchronizer plus debounce SHALL be one sub-module, btn_debounce (parameter DB_CNT), outputting the debounced level.
REQ-032 Edge detection, hold counter, FSM and config registers SHALL reside in dds_config_ctrl.

Verification (DB_CNT=4, LONG_CNT=20)
REQ-033 Reset release, Ready=1 -> Cfg_Valid high one cycle, Wave_Sel=0, Freq_Idx=0, Phase_Inc=PHASE_INC[0]; Enable=1 the next cycle.
REQ-034 Clean 10-cycle press, Ready=1 -> Freq_Idx 0->1, Wave_Sel=0, Phase_Inc=PHASE_INC[1], Enable low exactly while Cfg_Valid=1.
REQ-035 30-cycle press -> Wave_Sel 0->1, Freq_Idx unchanged; four long presses from 3 -> wraps to 0; eight short presses -> Freq_Idx wraps 7->0.
REQ-036 Bouncing input toggling every 2 cycles for 20 cycles, then steady low -> no state change, no Cfg_Valid.
REQ-037 Ready=0 for 15 cycles in UPDATE with a press during that time -> outputs stable, Cfg_Valid held, press dropped; single transfer on Ready=1.
REQ-038 RESET asserted mid-PRESS and mid-UPDATE -> REQ-028 values next cycle, then INIT_CFG default config.
